// File: rtl/id_insn_queue_pkg.sv
// Shared widths and constants for the ID-stage instruction queue.
// Optional zero-latency bypass is enabled by defining ID_IQ_BYPASS_EN.
package id_insn_queue_pkg;

    localparam int IQ_ADDR_W = 30;
    localparam int IQ_DATA_W = 32;
    localparam int IQ_DEPTH  = 4;
    localparam int IQ_PTR_W  = $clog2(IQ_DEPTH);
    localparam int IQ_CNT_W  = 16;

    // Value presented to the decoder when no entry is valid
    localparam logic [IQ_DATA_W-1:0] IQ_EMPTY_INSN = '0;

endpackage

// File: rtl/id_insn_queue_if.sv
// Fetch-side and decode-side handshake of the instruction queue.
// The queue is the slave; IF and the decoder together form the master.
interface id_insn_queue_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_insn;
    logic              if_en;
    logic              q_full;
    logic              ld_hazard;
    logic              br_taken;
    logic [ADDR_W-1:0] dec_pc;
    logic [DATA_W-1:0] dec_insn;
    logic              dec_en;

    modport master (
        output if_pc, if_insn, if_en, ld_hazard, br_taken,
        input  q_full, dec_pc, dec_insn, dec_en
    );

    modport slave (
        input  if_pc, if_insn, if_en, ld_hazard, br_taken,
        output q_full, dec_pc, dec_insn, dec_en
    );
endinterface

// File: rtl/id_insn_queue_stall_cnt.sv
// Saturating hazard-stall counter with synchronous clear; the clear wins over an increment.
// Kept generic so the EX and MEM stages can reuse it.
module id_iq_stall_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/id_insn_queue.sv
// Circular instruction buffer between IF and the ID decoder, with load-hazard stall accounting.
// Define ID_IQ_BYPASS_EN to forward a fetch straight to the decoder when the queue is empty.
module id_insn_queue
    import id_insn_queue_pkg::*;
#(
    parameter int ADDR_W = IQ_ADDR_W,
    parameter int DATA_W = IQ_DATA_W,
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = IQ_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    id_insn_queue_if.slave      iq,
    input  logic                stall,
    input  logic                flush,
    input  logic                ld_stall_clr,
    output logic [PTR_W:0]      q_count,
    output logic [CNT_W-1:0]    ld_stall_cnt
);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] insn_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              empty, byp, pop, pop_q, push, wr, kill;

    assign empty = (count == '0);

`ifdef ID_IQ_BYPASS_EN
    assign byp = empty & iq.if_en;
`else
    assign byp = 1'b0;
`endif

    assign iq.q_full = (count == FULL_CNT);
    assign iq.dec_en = ~empty | byp;
    assign q_count   = count;

    always_comb begin
        iq.dec_pc   = '0;
        iq.dec_insn = DATA_W'(IQ_EMPTY_INSN);
        if (!empty) begin
            iq.dec_pc   = pc_mem[rd_ptr];
            iq.dec_insn = insn_mem[rd_ptr];
        end else if (byp) begin
            iq.dec_pc   = iq.if_pc;
            iq.dec_insn = iq.if_insn;
        end
    end

    assign pop   = iq.dec_en & ~stall & ~iq.ld_hazard & ~flush;
    assign push  = iq.if_en & ~iq.q_full & ~flush & ~(iq.br_taken & pop);
    // A bypassed entry consumed in the same cycle never touches storage
    assign wr    = push & ~(byp & pop);
    assign pop_q = pop & ~empty;
    assign kill  = flush | (iq.br_taken & pop);

    always_ff @(posedge clk) begin
        if (reset || kill) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, pop_q})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[wr_ptr]   <= iq.if_pc;
            insn_mem[wr_ptr] <= iq.if_insn;
        end
    end

    id_iq_stall_cnt #(
        .CNT_W (CNT_W)
    ) u_ld_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ld_stall_clr),
        .inc   (iq.dec_en & iq.ld_hazard & ~stall & ~flush),
        .cnt   (ld_stall_cnt)
    );
endmodule

// File: tb/tb_id_insn_queue.sv
// Directed scoreboard bench for id_insn_queue (DEPTH=4, CNT_W=4 so saturation is reachable).
// Follows ID_IQ_BYPASS_EN when it is defined for the build.
module tb_id_insn_queue;
    import id_insn_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 4;
`ifdef ID_IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             stall, flush, ld_stall_clr;
    logic [PTR_W:0]   q_count;
    logic [CNT_W-1:0] ld_stall_cnt;

    id_insn_queue_if #(.ADDR_W(30), .DATA_W(32)) iq ();

    id_insn_queue #(
        .ADDR_W (30),
        .DATA_W (32),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .iq           (iq),
        .stall        (stall),
        .flush        (flush),
        .ld_stall_clr (ld_stall_clr),
        .q_count      (q_count),
        .ld_stall_cnt (ld_stall_cnt)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          step   = 0;
    logic [29:0] sb [$];
    int          mcnt   = 0;
    logic        cur_en;
    logic [29:0] cur_pc;

    function automatic logic [31:0] insn_of(input logic [29:0] pc);
        return {2'b10, pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s@%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic        exp_en;
        logic [29:0] exp_pc;
        exp_en = 1'b0;
        exp_pc = '0;
        if (sb.size() != 0) begin
            exp_en = 1'b1;
            exp_pc = sb[0];
        end else if (BYP && cur_en) begin
            exp_en = 1'b1;
            exp_pc = cur_pc;
        end
        chk("dec_en",   64'(iq.dec_en),   64'(exp_en));
        chk("dec_pc",   64'(iq.dec_pc),   64'(exp_pc));
        chk("dec_insn", 64'(iq.dec_insn), exp_en ? 64'(insn_of(exp_pc)) : 64'd0);
        chk("q_count",  64'(q_count),     64'(sb.size()));
        chk("q_full",   64'(iq.q_full),   64'(sb.size() == DEPTH));
        chk("ld_cnt",   64'(ld_stall_cnt), 64'(mcnt));
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge
    task automatic applyStimulus(input logic en, input logic [29:0] pc, input logic stl,
                                 input logic fl, input logic ld, input logic br, input logic clr);
        logic empty, byp, hv, pop, push, inc;
        cur_en = en;
        cur_pc = pc;
        iq.if_en = en;
        iq.if_pc = pc;
        iq.if_insn = insn_of(pc);
        iq.ld_hazard = ld;
        iq.br_taken = br;
        stall = stl;
        flush = fl;
        ld_stall_clr = clr;
        #2;
        checkOutput();
        empty = (sb.size() == 0);
        byp   = BYP && empty && en;
        hv    = !empty || byp;
        pop   = hv && !stl && !ld && !fl;
        push  = en && (sb.size() != DEPTH) && !fl && !(br && pop);
        inc   = hv && ld && !stl && !fl;
        if (fl || (br && pop)) begin
            sb.delete();
        end else begin
            if (pop && !empty) void'(sb.pop_front());
            if (push && !(byp && pop)) sb.push_back(pc);
        end
        if (clr) mcnt = 0;
        else if (inc && mcnt != (2**CNT_W - 1)) mcnt++;
        @(posedge clk);
        #1;
        step++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rstCycles(input int n);
        reset = 1'b1;
        iq.if_en = 1'b1;
        iq.if_pc = 30'h2ff;
        iq.if_insn = insn_of(30'h2ff);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        mcnt = 0;
    endtask

    initial begin
        iq.if_en = 1'b0; iq.if_pc = '0; iq.if_insn = '0;
        iq.ld_hazard = 1'b0; iq.br_taken = 1'b0;
        stall = 1'b0; flush = 1'b0; ld_stall_clr = 1'b0;
        cur_en = 1'b0; cur_pc = '0;
        rstCycles(2);
        idle(1);

        $display("[TB] fill to full under stall, then drain in order");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 30'h100 + 30'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 30'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 30'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 30'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        $display("[TB] push and pop every cycle across pointer wrap");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 30'h110 + 30'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        $display("[TB] branch taken on head discards younger entries");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 30'h200 + 30'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 30'h203, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        $display("[TB] flush with push, then reset mid-stream");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 30'h210 + 30'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 30'h213, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 30'h218 + 30'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rstCycles(4);
        idle(1);

        $display("[TB] load-hazard stall counting, saturation and clear");
        applyStimulus(1'b1, 30'h220, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ld_cnt_5", 64'(ld_stall_cnt), 64'd5);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ld_cnt_sat", 64'(ld_stall_cnt), 64'd15);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);

        $display("[TB] fetch into empty queue, popped and stalled");
        applyStimulus(1'b1, 30'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b1, 30'h301, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
